// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver with 2-flop input synchronizer, mid-bit
//             sampling, glitch rejection on the start bit and frame-error
//             detection on the stop bit.
//  Ports    : i_clk       - system clock, rising-edge active
//             i_rst       - asynchronous active-high reset
//             i_serialRX  - asynchronous serial line, idle high, LSB first
//             o_data[7:0] - last correctly framed byte (held until next one)
//             o_done      - one-cycle pulse, o_data has just been updated
//             o_busy      - high while a frame is in progress
//             o_frameErr  - one-cycle pulse, stop bit was sampled low
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_serialRX,
    output logic [7:0] o_data,
    output logic       o_done,
    output logic       o_busy,
    output logic       o_frameErr
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    // Counter compare points: half a bit to reach the middle of the start
    // bit, then whole bits so every later sample also lands mid-bit.
    localparam logic [15:0] C_HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] C_BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    logic        r_sync_meta;
    logic        r_rx_s;
    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;

    logic w_half_hit;
    logic w_bit_hit;
    logic w_cnt_clear;
    logic w_sample_data;
    logic w_good_stop;
    logic w_bad_stop;

    assign w_half_hit = (r_cnt == C_HALF_LAST);
    assign w_bit_hit  = (r_cnt == C_BIT_LAST);

    // Synchronizer flops reset high so a reset never looks like a start bit
    // unless the line really is low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync_meta <= 1'b1;
            r_rx_s      <= 1'b1;
        end else begin
            r_sync_meta <= i_serialRX;
            r_rx_s      <= r_sync_meta;
        end
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) w_next_state = S_START;
            end
            S_START: begin
                // A line that is high again at mid start bit was a glitch.
                if (w_half_hit) w_next_state = r_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_bit_hit && (r_idx == 3'd7)) w_next_state = S_STOP;
            end
            S_STOP: begin
                if (w_bit_hit) w_next_state = r_rx_s ? S_IDLE : S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                // Break / stuck-low line: wait for idle before hunting again.
                if (r_rx_s) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output / datapath control decode
    always_comb begin
        w_cnt_clear   = 1'b0;
        w_sample_data = 1'b0;
        w_good_stop   = 1'b0;
        w_bad_stop    = 1'b0;
        case (r_state)
            S_IDLE:      w_cnt_clear = 1'b1;
            S_START:     w_cnt_clear = w_half_hit;
            S_DATA: begin
                w_cnt_clear   = w_bit_hit;
                w_sample_data = w_bit_hit;
            end
            S_STOP: begin
                w_cnt_clear = w_bit_hit;
                w_good_stop = w_bit_hit &&  r_rx_s;
                w_bad_stop  = w_bit_hit && !r_rx_s;
            end
            S_WAIT_IDLE: w_cnt_clear = 1'b1;
            default:     w_cnt_clear = 1'b1;
        endcase
    end

    // Datapath and registered outputs. o_busy follows the next state so it
    // is already low in the cycle o_done is high after a good stop bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt      <= 16'd0;
            r_idx      <= 3'd0;
            r_shift    <= 8'h00;
            o_data     <= 8'h00;
            o_done     <= 1'b0;
            o_busy     <= 1'b0;
            o_frameErr <= 1'b0;
        end else begin
            r_cnt <= w_cnt_clear ? 16'd0 : r_cnt + 16'd1;

            if (r_state == S_START) begin
                r_idx <= 3'd0;
            end else if (w_sample_data) begin
                r_idx <= r_idx + 3'd1;
            end

            if (w_sample_data) begin
                r_shift[r_idx] <= r_rx_s;
            end

            if (w_good_stop) begin
                o_data <= r_shift;
            end

            o_done     <= w_good_stop;
            o_frameErr <= w_bad_stop;
            o_busy     <= (w_next_state != S_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Directed self-checking bench for uart_rx. A schedule model
//             derived from the frame timing predicts o_done / o_frameErr /
//             o_data / o_busy per cycle; literal checks pin the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int C   = 16;
    // Raw line fall to o_done/o_frameErr visible: 2 synchronizer cycles plus
    // the 153-cycle latency measured from the first synchronized low.
    localparam int LAT = 2 + 153;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] o_data;
    logic       o_done;
    logic       o_busy;
    logic       o_frameErr;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_serialRX (rx),
        .o_data     (o_data),
        .o_done     (o_done),
        .o_busy     (o_busy),
        .o_frameErr (o_frameErr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    bit         run_cmp    = 1'b0;
    logic [7:0] model_data = 8'h00;
    bit         exp_done[int];
    bit         exp_err[int];
    logic [7:0] exp_byte[int];
    bit         exp_busy[int];
    int         done_q[$];
    int         done_count = 0;
    int         err_count  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Per-cycle comparison against the schedule model
    always @(negedge clk) begin
        if (run_cmp) begin
            if (exp_done.exists(cyc)) model_data = exp_byte[cyc];
            chk("done",      {31'd0, o_done},     {31'd0, exp_done.exists(cyc) == 1});
            chk("frame_err", {31'd0, o_frameErr}, {31'd0, exp_err.exists(cyc) == 1});
            chk("data",      {24'd0, o_data},     {24'd0, model_data});
            if (exp_busy.exists(cyc))
                chk("busy", {31'd0, o_busy}, {31'd0, exp_busy[cyc]});
            if (o_done) begin
                done_q.push_back(cyc);
                done_count++;
            end
            if (o_frameErr) err_count++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives the first n bits of a 10-bit frame, one bit per C cycles.
    task automatic drive_bits(input logic [9:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            rx = f[i];
            repeat (C) @(posedge clk);
            #1;
        end
    endtask

    // Full frame; the outcome is scheduled relative to the start-bit fall.
    task automatic send_frame(input logic [7:0] b, input bit stop);
        int k;
        k = cyc;
        if (stop) begin
            exp_done[k + LAT] = 1'b1;
            exp_byte[k + LAT] = b;
            for (int t = k + 3; t < k + LAT; t++) exp_busy[t] = 1'b1;
            exp_busy[k + LAT] = 1'b0;
        end else begin
            exp_err[k + LAT] = 1'b1;
        end
        drive_bits({stop, b, 1'b0}, 10);
    endtask

    initial begin
        int k0;
        int d0;
        int e0;
        int q0;
        int busy_cnt;

        rst = 1'b1;
        rx  = 1'b1;
        idle(3);
        chk("reset_data",  {24'd0, o_data}, 32'h00);
        chk("reset_done",  {31'd0, o_done}, 32'h0);
        chk("reset_busy",  {31'd0, o_busy}, 32'h0);
        chk("reset_ferr",  {31'd0, o_frameErr}, 32'h0);
        rst = 1'b0;
        run_cmp = 1'b1;
        idle(10);

        // Good frame 0xA5
        k0 = cyc; d0 = done_count;
        send_frame(8'hA5, 1'b1);
        chk("a5_pulses",  done_count - d0, 1);
        chk("a5_latency", (done_q.size() > 0) ? done_q[$] - k0 : -1, 155);
        chk("a5_data",    {24'd0, o_data}, 32'hA5);
        chk("a5_no_ferr", err_count, 0);

        // Four-cycle glitch on an idle line
        idle(10);
        d0 = done_count; busy_cnt = 0;
        rx = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (i == 3) rx = 1'b1;
            busy_cnt += int'(o_busy);
        end
        chk("glitch_busy_max",  {31'd0, busy_cnt <= 8}, 32'h1);
        chk("glitch_busy_seen", {31'd0, busy_cnt > 0},  32'h1);
        chk("glitch_no_done",   done_count - d0, 0);
        chk("glitch_data",      {24'd0, o_data}, 32'hA5);

        // 0x11 good, then 0x3C with a low stop bit and a stuck-low line
        idle(8);
        send_frame(8'h11, 1'b1);
        idle(8);
        e0 = err_count;
        send_frame(8'h3C, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        chk("ferr_busy_held", {31'd0, o_busy}, 32'h1);
        rx = 1'b1;
        idle(20);
        chk("ferr_pulses", err_count - e0, 1);
        chk("ferr_data",   {24'd0, o_data}, 32'h11);
        send_frame(8'h55, 1'b1);
        idle(4);
        chk("after_ferr_data", {24'd0, o_data}, 32'h55);

        // Back-to-back 0x00 then 0xFF
        idle(10);
        q0 = done_q.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(4);
        chk("b2b_pulses", done_q.size() - q0, 2);
        chk("b2b_spacing", (done_q.size() >= q0 + 2) ? done_q[q0 + 1] - done_q[q0] : -1, 160);
        chk("b2b_data", {24'd0, o_data}, 32'hFF);

        // Reset during data bit 4 of 0x5A
        idle(10);
        d0 = done_count; e0 = err_count;
        drive_bits({1'b1, 8'h5A, 1'b0}, 5);
        rx = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        model_data = 8'h00;
        #1;
        chk("abort_data", {24'd0, o_data}, 32'h00);
        chk("abort_busy", {31'd0, o_busy}, 32'h0);
        idle(3);
        rst = 1'b0;
        idle(20);
        send_frame(8'hC3, 1'b1);
        idle(4);
        chk("abort_pulses", done_count - d0, 1);
        chk("abort_no_ferr", err_count - e0, 0);
        chk("c3_data", {24'd0, o_data}, 32'hC3);

        run_cmp = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
